// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the 8-bit program/data memory bus between the CPU
// instruction-cycle controller and the DMA/loader port.
//
// Ownership is held in a registered grant FSM (IDLE, OWN_CPU, OWN_DMA, TURN).
// Ties in IDLE go round-robin against the last owner. A turnaround cycle is
// inserted between owners. DMA is force-released when it holds the bus too
// long while the CPU waits. The CPU is never preempted.
//
// Optional build macro ARB_STATS_EN adds saturating wait/preemption counters
// on stat_cpu_wait / stat_preempt. Without it both ports are tied to zero.
//
// Handshake: a master raises req and keeps it high for its whole
// transaction. gnt rises one edge after req is sampled in IDLE. rd/wr/addr/
// wdata are only looked at while that master's gnt is high.
module mem_bus_arbiter #(
    parameter int AW           = 13,
    parameter int DW           = 8,
    parameter int DMA_MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    input  logic          dma_req,
    input  logic          dma_rd,
    input  logic          dma_wr,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          proto_err,
    output logic [15:0]   stat_cpu_wait,
    output logic [15:0]   stat_preempt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_OWN_CPU = 2'd1,
        S_OWN_DMA = 2'd2,
        S_TURN    = 2'd3
    } state_t;

    // hold_cnt counts DMA cycles with the CPU pending. The cycle that would
    // take it to DMA_MAX_HOLD-1 is the last one DMA keeps the bus.
    localparam logic [7:0] HOLD_LAST = 8'(DMA_MAX_HOLD - 2);

    state_t        state_q, state_d;
    logic          last_dma_q, last_dma_d;   // 1: DMA was the last owner
    logic [7:0]    hold_cnt_q, hold_cnt_d;
    logic          proto_err_q, proto_err_d;
    logic          own_rd, own_wr;

    // Next-state logic: arbitration, release, turnaround and DMA hold limit.
    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req && dma_req) begin
                    state_d = last_dma_q ? S_OWN_CPU : S_OWN_DMA;
                end else if (cpu_req) begin
                    state_d = S_OWN_CPU;
                end else if (dma_req) begin
                    state_d = S_OWN_DMA;
                end
            end
            S_OWN_CPU: begin
                if (!cpu_req) begin
                    state_d    = S_TURN;
                    last_dma_d = 1'b0;
                end
            end
            S_OWN_DMA: begin
                if (!dma_req) begin
                    state_d    = S_TURN;
                    last_dma_d = 1'b1;
                    hold_cnt_d = 8'd0;
                end else if (cpu_req) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = S_TURN;
                        last_dma_d = 1'b1;
                        hold_cnt_d = 8'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end else begin
                    hold_cnt_d = 8'd0;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory mux from the registered owner; rd+wr together suppresses the write.
    always_comb begin
        own_rd    = 1'b0;
        own_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_OWN_CPU: begin
                own_rd    = cpu_rd;
                own_wr    = cpu_wr;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            S_OWN_DMA: begin
                own_rd    = dma_rd;
                own_wr    = dma_wr;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: begin
                own_rd    = 1'b0;
                own_wr    = 1'b0;
            end
        endcase
        mem_rd      = own_rd;
        mem_wr      = own_wr & ~own_rd;
        proto_err_d = own_rd & own_wr;
    end

    // State, round-robin memory, hold counter and protocol-error register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            last_dma_q  <= 1'b1;
            hold_cnt_q  <= 8'd0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dma_q  <= last_dma_d;
            hold_cnt_q  <= hold_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign cpu_gnt   = (state_q == S_OWN_CPU);
    assign dma_gnt   = (state_q == S_OWN_DMA);
    assign proto_err = proto_err_q;

`ifdef ARB_STATS_EN
    logic [15:0] cpu_wait_q, cpu_wait_d;
    logic [15:0] preempt_q, preempt_d;
    logic        preempt;

    // A forced release is a DMA exit taken only because of the hold limit.
    assign preempt = (state_q == S_OWN_DMA) && dma_req && cpu_req &&
                     (hold_cnt_q == HOLD_LAST);

    // Saturating counters for CPU wait cycles and DMA preemptions.
    always_comb begin
        cpu_wait_d = cpu_wait_q;
        preempt_d  = preempt_q;
        if (cpu_req && (state_q != S_OWN_CPU) && (cpu_wait_q != 16'hFFFF)) begin
            cpu_wait_d = cpu_wait_q + 16'd1;
        end
        if (preempt && (preempt_q != 16'hFFFF)) begin
            preempt_d = preempt_q + 16'd1;
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_wait_q <= 16'd0;
            preempt_q  <= 16'd0;
        end else begin
            cpu_wait_q <= cpu_wait_d;
            preempt_q  <= preempt_d;
        end
    end

    assign stat_cpu_wait = cpu_wait_q;
    assign stat_preempt  = preempt_q;
`else
    assign stat_cpu_wait = 16'd0;
    assign stat_preempt  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against an ownership-level reference model.
module tb_mem_bus_arbiter;

  localparam int AW   = 13;
  localparam int DW   = 8;
  localparam int MAXH = 16;
  localparam int W    = 58;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cpu_req, cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          dma_req, dma_rd, dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          proto_err;
  logic [15:0]   stat_cpu_wait, stat_preempt;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .DMA_MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .dma_req(dma_req), .dma_rd(dma_rd), .dma_wr(dma_wr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .proto_err(proto_err), .stat_cpu_wait(stat_cpu_wait), .stat_preempt(stat_preempt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0] exp_q[$];

  // Who owns the bus (0 none, 1 cpu, 2 dma), whether the mandatory gap
  // cycle is still pending, who owned last, and how long the CPU has been
  // kept waiting by the current DMA tenure.
  int m_owner, m_last, m_pend, m_wait, m_pre;
  bit m_gap, m_perr;

  function automatic void model_reset();
    m_owner = 0; m_last = 2; m_pend = 0; m_wait = 0; m_pre = 0;
    m_gap = 0; m_perr = 0;
  endfunction

  function automatic logic [W-1:0] model_expect();
    logic r, w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [15:0] sw, sp;
    r = 1'b0; w = 1'b0; a = '0; d = '0;
    if (m_owner == 1) begin
      r = cpu_rd; w = cpu_wr; a = cpu_addr; d = cpu_wdata;
    end else if (m_owner == 2) begin
      r = dma_rd; w = dma_wr; a = dma_addr; d = dma_wdata;
    end
    if (r && w) w = 1'b0;
`ifdef ARB_STATS_EN
    sw = 16'(m_wait); sp = 16'(m_pre);
`else
    sw = 16'd0; sp = 16'd0;
`endif
    return {(m_owner == 1), (m_owner == 2), r, w, a, d, m_perr, sw, sp};
  endfunction

  // Advance the model by one clock using the inputs present at the edge.
  function automatic void model_step();
    m_perr = (m_owner == 1 && cpu_rd && cpu_wr) || (m_owner == 2 && dma_rd && dma_wr);
    if (cpu_req && m_owner != 1 && m_wait < 65535) m_wait++;
    if (m_owner == 1) begin
      if (!cpu_req) begin m_owner = 0; m_gap = 1; m_last = 1; end
    end else if (m_owner == 2) begin
      if (!dma_req) begin
        m_owner = 0; m_gap = 1; m_last = 2; m_pend = 0;
      end else if (cpu_req) begin
        m_pend++;
        if (m_pend == MAXH - 1) begin
          m_owner = 0; m_gap = 1; m_last = 2; m_pend = 0;
          if (m_pre < 65535) m_pre++;
        end
      end else begin
        m_pend = 0;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (cpu_req && dma_req) begin
      m_owner = (m_last == 2) ? 1 : 2;
    end else if (cpu_req) begin
      m_owner = 1;
    end else if (dma_req) begin
      m_owner = 2;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cpu_req = 0; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_rd = 0; dma_wr = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, mem_rd, mem_wr, proto_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {cpu_gnt, dma_gnt, mem_rd, mem_wr, proto_err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr %h data %h want 0", mem_addr, mem_wdata);
    end
    n_checks++;
    if ({stat_cpu_wait, stat_preempt} !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_stats: got %h %h want 0", stat_cpu_wait, stat_preempt);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_cpu_grant();
    do_reset();
    cpu_req = 1; cpu_rd = 1; cpu_addr = 13'h0A5;
    #1;
    n_checks++;
    if (cpu_gnt !== 1'b0 || mem_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_pre_grant: got gnt %b mem_rd %b want 0 0", cpu_gnt, mem_rd);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, mem_rd, mem_addr} !== {3'b101, 13'h0A5}) begin
      n_fail++;
      $display("FAIL cpu_grant: got gnt %b/%b rd %b addr %h want 1/0 1 0a5",
               cpu_gnt, dma_gnt, mem_rd, mem_addr);
    end
    cpu_req = 0; cpu_rd = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt, mem_rd} !== 3'b000) begin
      n_fail++;
      $display("FAIL cpu_release_turn: got %b want 000", {cpu_gnt, dma_gnt, mem_rd});
    end
  endtask

  task automatic test_tie();
    do_reset();
    cpu_req = 1; dma_req = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_first_cpu: got %b want 10", {cpu_gnt, dma_gnt});
    end
    @(posedge clk); #1;
    cpu_req = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL tie_turn: got %b want 00", {cpu_gnt, dma_gnt});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL tie_idle_gap: got %b want 00", {cpu_gnt, dma_gnt});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL tie_then_dma: got %b want 01", {cpu_gnt, dma_gnt});
    end
  endtask

  task automatic test_preempt();
    int n;
    logic [15:0] want_pre, want_wait;
    do_reset();
    dma_req = 1;
    @(posedge clk); #1;
    n_checks++;
    if (dma_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL preempt_dma_grant: got %b want 1", dma_gnt);
    end
    cpu_req = 1;
    n = 0;
    for (int k = 0; k < 40 && dma_gnt === 1'b1; k++) begin
      n++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n != MAXH - 1) begin
      n_fail++;
      $display("FAIL preempt_hold_len: got %0d cycles want %0d", n, MAXH - 1);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL preempt_gap: got %b want 00", {cpu_gnt, dma_gnt});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL preempt_cpu_grant: got %b want 10", {cpu_gnt, dma_gnt});
    end
`ifdef ARB_STATS_EN
    want_pre = 16'd1; want_wait = 16'd17;
`else
    want_pre = 16'd0; want_wait = 16'd0;
`endif
    n_checks++;
    if (stat_preempt !== want_pre || stat_cpu_wait !== want_wait) begin
      n_fail++;
      $display("FAIL preempt_stats: got pre %0d wait %0d want %0d %0d",
               stat_preempt, stat_cpu_wait, want_pre, want_wait);
    end
    cpu_req = 0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL preempt_regrant: got %b want 01", {cpu_gnt, dma_gnt});
    end
  endtask

  task automatic test_dma_write();
    do_reset();
    dma_req = 1; dma_wr = 1; dma_addr = 13'h1FFF; dma_wdata = 8'h3C;
    @(posedge clk); #1;
    n_checks++;
    if ({dma_gnt, mem_wr, mem_addr, mem_wdata} !== {2'b11, 13'h1FFF, 8'h3C}) begin
      n_fail++;
      $display("FAIL dma_write: got gnt %b wr %b addr %h data %h want 1 1 1fff 3c",
               dma_gnt, mem_wr, mem_addr, mem_wdata);
    end
    for (int k = 0; k < 6; k++) begin
      cpu_wr    = k[0];
      dma_wr    = ~k[0];
      cpu_addr  = AW'($urandom);
      cpu_wdata = DW'($urandom);
      #1;
      n_checks++;
      if ({mem_wr, mem_addr, mem_wdata} !== {~k[0], 13'h1FFF, 8'h3C}) begin
        n_fail++;
        $display("FAIL dma_ignore_cpu[%0d]: got wr %b addr %h data %h want %b 1fff 3c",
                 k, mem_wr, mem_addr, mem_wdata, ~k[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    cpu_req = 1;
    @(posedge clk); #1;
    cpu_rd = 1; cpu_wr = 1;
    #1;
    n_checks++;
    if ({cpu_gnt, mem_rd, mem_wr, proto_err} !== 4'b1100) begin
      n_fail++;
      $display("FAIL proto_mux: got gnt/rd/wr/err %b want 1100",
               {cpu_gnt, mem_rd, mem_wr, proto_err});
    end
    @(posedge clk); #1;
    cpu_wr = 0;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_pulse: got %b want 1", proto_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_pulse_end: got %b want 0", proto_err);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    dma_req = 1; dma_wr = 1; dma_addr = 13'h1ABC; dma_wdata = 8'h55;
    @(posedge clk); #1;
    n_checks++;
    if (mem_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre: got mem_wr %b want 1", mem_wr);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({mem_wr, dma_gnt, mem_addr} !== {2'b00, 13'h0}) begin
      n_fail++;
      $display("FAIL async_drop: got wr %b gnt %b addr %h want 0 0 0", mem_wr, dma_gnt, mem_addr);
    end
    cpu_req = 1;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({cpu_gnt, dma_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL async_tie_cpu: got %b want 10", {cpu_gnt, dma_gnt});
    end
  endtask

  task automatic test_random();
    logic [W-1:0] obs, want;
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (cpu_req) cpu_req = ($urandom_range(0, 19) != 0);
      else         cpu_req = ($urandom_range(0, 3) == 0);
      if (dma_req) dma_req = ($urandom_range(0, 29) != 0);
      else         dma_req = ($urandom_range(0, 2) == 0);
      cpu_rd = 1'($urandom_range(0, 1));
      cpu_wr = cpu_rd ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      dma_rd = 1'($urandom_range(0, 1));
      dma_wr = dma_rd ? ($urandom_range(0, 7) == 0) : 1'($urandom_range(0, 1));
      cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
      dma_addr = AW'($urandom); dma_wdata = DW'($urandom);
      #3;
      exp_q.push_back(model_expect());
      obs  = {cpu_gnt, dma_gnt, mem_rd, mem_wr, mem_addr, mem_wdata, proto_err,
              stat_cpu_wait, stat_preempt};
      want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_fail++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, want);
      end
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_cpu_grant();
    test_tie();
    test_preempt();
    test_dma_write();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
